// File: rtl/xip_flash_reader.sv
// Execute-in-place SPI NOR reader: turns 32-bit fetch requests into READ (0x03)
// transactions, keeping chip-select low across sequential fetches.
module xip_flash_reader #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CS_HIGH     = 4,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        xip_csn,
  output logic        xip_clk,
  output logic        xip_sdo,
  input  logic        xip_sdi
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CSH_W  = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CSH_W-1:0]  CSH_LOAD  = CSH_W'(CS_HIGH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [7:0]        READ_CMD  = 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [5:0]         bit_cnt, bit_n;
  logic [30:0]        tx, tx_n;
  logic [30:0]        rx, rx_n;
  logic [23:0]        addr, addr_n;
  logic [23:0]        next_addr, next_addr_n;
  logic [CSH_W-1:0]   desel_cnt, desel_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic               pending, pending_n;
  logic               csn_n, sclk_n, sdo_n, rsp_valid_n, req_ready_n;
  logic [31:0]        rsp_data_n;

  logic [23:0]        req_aligned;
  logic [23:0]        start_addr;
  logic [31:0]        cmd_word;
  logic [31:0]        rx_full;
  logic               start_cmd, enter_desel;

  assign req_aligned = req_addr & 24'hFFFFFC;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= DESEL;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      addr      <= '0;
      next_addr <= '0;
      desel_cnt <= CSH_LOAD;
      hold_cnt  <= '0;
      pending   <= 1'b0;
      xip_csn   <= 1'b1;
      xip_clk   <= 1'b0;
      xip_sdo   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      tx        <= tx_n;
      rx        <= rx_n;
      addr      <= addr_n;
      next_addr <= next_addr_n;
      desel_cnt <= desel_n;
      hold_cnt  <= hold_n;
      pending   <= pending_n;
      xip_csn   <= csn_n;
      xip_clk   <= sclk_n;
      xip_sdo   <= sdo_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      req_ready <= req_ready_n;
    end
  end

  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    bit_n       = bit_cnt;
    tx_n        = tx;
    rx_n        = rx;
    addr_n      = addr;
    next_addr_n = next_addr;
    desel_n     = desel_cnt;
    hold_n      = hold_cnt;
    pending_n   = pending;
    csn_n       = xip_csn;
    sclk_n      = xip_clk;
    sdo_n       = xip_sdo;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    start_cmd   = 1'b0;
    enter_desel = 1'b0;
    start_addr  = addr;
    cmd_word    = '0;
    rx_full     = {rx, xip_sdi};

    case (state)
      IDLE: begin
        if (req_valid) begin
          start_cmd  = 1'b1;
          start_addr = req_aligned;
          addr_n     = req_aligned;
        end
      end
      DESEL: begin
        if (desel_cnt == '0) begin
          if (pending) begin
            start_cmd = 1'b1;
            pending_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          desel_n = desel_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (req_valid) begin
          // Continuation only for a true successor; a wrap to zero restarts the flash.
          if (req_aligned == next_addr && next_addr != '0) begin
            state_n = DATA;
            bit_n   = 6'd32;
            div_n   = '0;
            sclk_n  = 1'b0;
            addr_n  = next_addr;
          end else begin
            addr_n      = req_aligned;
            pending_n   = 1'b1;
            enter_desel = 1'b1;
          end
        end else if (hold_cnt == '0) begin
          enter_desel = 1'b1;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      CMD, ADDR, DATA: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n = '0;
          if (!xip_clk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            bit_n  = bit_cnt - 1'b1;
            rx_n   = rx_full[30:0];
            sdo_n  = tx[30];
            tx_n   = {tx[29:0], 1'b0};
            if (bit_cnt == 6'd1) begin
              if (state == CMD) begin
                state_n = ADDR;
                bit_n   = 6'd24;
              end else if (state == ADDR) begin
                state_n = DATA;
                bit_n   = 6'd32;
                sdo_n   = 1'b0;
              end else begin
                rsp_valid_n = 1'b1;
                rsp_data_n  = {rx_full[7:0], rx_full[15:8], rx_full[23:16], rx_full[31:24]};
                next_addr_n = addr + 24'd4;
                if (HOLD_CYCLES == 0) begin
                  enter_desel = 1'b1;
                  pending_n   = 1'b0;
                end else begin
                  state_n = HOLD;
                  hold_n  = HOLD_LOAD;
                end
              end
            end
          end
        end
      end
      default: enter_desel = 1'b1;
    endcase

    if (start_cmd) begin
      cmd_word = {READ_CMD, start_addr};
      state_n  = CMD;
      csn_n    = 1'b0;
      sclk_n   = 1'b0;
      sdo_n    = cmd_word[31];
      tx_n     = cmd_word[30:0];
      bit_n    = 6'd8;
      div_n    = '0;
    end
    if (enter_desel) begin
      state_n = DESEL;
      csn_n   = 1'b1;
      sclk_n  = 1'b0;
      sdo_n   = 1'b0;
      desel_n = CSH_LOAD;
    end

    req_ready_n = (state_n == IDLE) || (state_n == HOLD);
  end

endmodule
